pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//   Supervises the core PLL from its free-running reference clock. Pulses the PLL rst for a fixed time,
//   waits for a stable `locked`, then releases a system reset request and flags ready.
//   On lock loss, timeout or software request it re-runs the PLL reset sequence.
//   sys_rst is per-domain re-synchronised downstream into each PLL output clock domain.
// PARAMETERS
//   SYNC_STAGES          2        flops in the `locked` synchroniser chain (>=2)
//   PLL_RST_CYCLES       16       cycles pll_rst is held high per sequence (>=1)
//   LOCK_TIMEOUT_CYCLES  65536    cycles allowed in WAIT_LOCK before re-resetting the PLL (>=1)
//   LOCK_HOLD_CYCLES     1024     cycles locked_sync must stay high before RUN (>=1)
// PORTS
//   clk           in   1   PLL reference clock (74.25 MHz), free-running
//   rst           in   1   synchronous, active-high reset
//   locked        in   1   PLL locked, asynchronous to clk
//   req_reset     in   1   single-cycle request to restart the PLL sequence
//   pll_rst       out  1   drive to PLL rst
//   sys_rst       out  1   system reset request, high whenever not in RUN
//   ready         out  1   high only in RUN
//   relock_count  out  8   saturating count of lock losses seen in RUN
// BEHAVIOUR
// - Reset: while rst is high, state=S_PLL_RST, timer=0, sync chain=0, pll_rst=1, sys_rst=1, ready=0, relock_count=0.
// - Sync chain: locked_sync = locked delayed by SYNC_STAGES clk edges.
// - All outputs are registered and Moore-decoded from the next state.
//   - pll_rst = (state==S_PLL_RST)
//   - sys_rst = (state!=S_RUN)
//   - ready   = (state==S_RUN)
// - Single timer, width $clog2(max of cycle params). It is cleared on every state entry and increments otherwise.
// - States and transitions (req_reset has top priority in every state):
//   - S_PLL_RST: when timer==PLL_RST_CYCLES-1, go to S_WAIT_LOCK.
//   - S_WAIT_LOCK:
//     - locked_sync=1: go to S_HOLD.
//     - else timer==LOCK_TIMEOUT_CYCLES-1: go to S_PLL_RST.
//   - S_HOLD:
//     - locked_sync=0: go to S_WAIT_LOCK.
//     - else timer==LOCK_HOLD_CYCLES-1: go to S_RUN.
//   - S_RUN: locked_sync=0 -> S_PLL_RST and relock_count+1, saturating at 255.
//   - req_reset=1 in any state: go to S_PLL_RST with timer=0. If already in S_PLL_RST, the timer restarts.
// - Simultaneous req_reset and lock loss in S_RUN: one transition to S_PLL_RST; relock_count still increments.
// - Latency: from rst release with locked_sync high, pll_rst falls after PLL_RST_CYCLES edges.
//   ready rises PLL_RST_CYCLES+1+LOCK_HOLD_CYCLES edges after rst release.
// - Timeouts and req_reset never change relock_count.
// CONFIGURATION
// - PLL_LOCK_STATS_EN defined:
//   - relock_count is live as specified.
//   - An extra output timeout_count[7:0] counts WAIT_LOCK timeouts, saturating at 255, reset to 0.
// - PLL_LOCK_STATS_EN undefined:
//   - Both counters are omitted.
//   - relock_count is tied to 8'd0 and timeout_count is absent.
// STRUCTURE
// - pll_seq_pkg:
//   - typedef enum logic [1:0] {S_PLL_RST, S_WAIT_LOCK, S_HOLD, S_RUN} pll_seq_state_t
//   - localparam STAT_W=8
//   - function cnt_width(max) wrapping $clog2.
// - Sub-module bit_synchronizer (parameter STAGES; ports clk, rst, d, q) implements the locked chain.
// - FSM, timer and counters live in this module.
// TESTING (SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_HOLD_CYCLES=8, PLL_LOCK_STATS_EN defined)
// - Power-up: hold rst 3 cycles, locked=1 throughout -> pll_rst high through edge 4 after release, low from edge 4.
//   ready=1 and sys_rst=0 from edge 13.
// - No lock: locked=0 forever -> pll_rst 4-cycle pulses every 36 cycles, ready never 1, timeout_count increments per pulse.
// - Hold glitch: locked low for 1 cycle mid-HOLD -> state returns to WAIT_LOCK, then a full fresh 8-cycle hold;
//   ready rises 9 cycles after locked_sync returns high.
// - Lock loss in RUN: locked falls -> 2 edges later pll_rst=1, sys_rst=1, ready=0, relock_count 0->1.
//   Repeat 300 times -> relock_count=255.
// - req_reset at S_PLL_RST timer=2 -> pll_rst stays high 4 further cycles.
//   req_reset with lock loss in RUN -> single sequence, relock_count+1.
// - rst asserted mid-HOLD with relock_count=5 -> next edge: pll_rst=1, sys_rst=1, ready=0, counts=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {S_PLL_RST, S_WAIT_LOCK, S_HOLD, S_RUN} pll_seq_state_t;

    localparam int STAT_W = 8;

    // Counter width able to hold 0..max_val-1; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing a single asynchronous bit into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, then releases the system reset and flags ready.
// Lock statistics (relock_count live, timeout_count port) are built only with PLL_LOCK_STATS_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_HOLD_CYCLES    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic              req_reset,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
`ifdef PLL_LOCK_STATS_EN
    output logic [STAT_W-1:0] timeout_count,
`endif
    output logic [STAT_W-1:0] relock_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_HOLD_CYCLES) ? MAX_A : LOCK_HOLD_CYCLES;
    localparam int TMR_W   = cnt_width(MAX_CYC);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(LOCK_HOLD_CYCLES - 1);

    pll_seq_state_t   state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             locked_sync;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PLL_RST;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // req_reset overrides every state and also restarts an in-progress PLL reset pulse.
    always_comb begin
        state_d = state_q;
        if (req_reset) begin
            state_d = S_PLL_RST;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_sync)               state_d = S_HOLD;
                    else if (timer_q == TO_LAST)   state_d = S_PLL_RST;
                end
                S_HOLD: begin
                    if (!locked_sync)              state_d = S_WAIT_LOCK;
                    else if (timer_q == HOLD_LAST) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!locked_sync) state_d = S_PLL_RST;
                end
                default: state_d = S_PLL_RST;
            endcase
        end
        timer_d = (req_reset || (state_d != state_q)) ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;

`ifdef PLL_LOCK_STATS_EN
    logic              lock_lost, timeout_hit;
    logic [STAT_W-1:0] relock_q, timeout_q;

    // A lock loss in RUN counts even when req_reset arrives on the same edge; a timeout
    // only counts when it actually causes the transition.
    assign lock_lost   = (state_q == S_RUN) && !locked_sync;
    assign timeout_hit = (state_q == S_WAIT_LOCK) && !req_reset && !locked_sync
                         && (timer_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            relock_q  <= '0;
            timeout_q <= '0;
        end else begin
            if (lock_lost && (relock_q != '1))    relock_q  <= relock_q + 1'b1;
            if (timeout_hit && (timeout_q != '1)) timeout_q <= timeout_q + 1'b1;
        end
    end

    assign relock_count  = relock_q;
    assign timeout_count = timeout_q;
`else
    assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboarded bench for pll_lock_sequencer: a phase-level reference model predicts every
// cycle's outputs, and a negedge monitor compares them against the design.
module tb_pll_lock_sequencer;

    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int TO   = 32;
    localparam int HOLD = 8;
`ifdef PLL_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_HOLD  = 2;
    localparam int P_RUN   = 3;

    logic       clk = 1'b0;
    logic       rst, locked, req_reset;
    logic       pll_rst, sys_rst, ready;
    logic [7:0] relock_count, timeout_count_w;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .SYNC_STAGES         (SYNC),
        .PLL_RST_CYCLES      (RSTC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_HOLD_CYCLES    (HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .req_reset     (req_reset),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
`ifdef PLL_LOCK_STATS_EN
        .timeout_count (timeout_count_w),
`endif
        .relock_count  (relock_count)
    );
`ifndef PLL_LOCK_STATS_EN
    assign timeout_count_w = 8'd0;
`endif

    typedef struct {
        bit pr;
        bit sr;
        bit rd;
        int rc;
        int tc;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];
    int   ph, t, rc, tc;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lk       = 1'b1;
    exp_t e;

    // Reference model: phase + time-in-phase, locked seen through a SYNC-deep history queue.
    task automatic model_edge(input bit r, input bit l, input bit q);
        bit ls;
        int nph;
        if (r) begin
            ph = P_PULSE; t = 0; rc = 0; tc = 0;
            hist.delete();
            repeat (SYNC) hist.push_back(1'b0);
        end else begin
            ls  = hist[0];
            nph = ph;
            if (ph == P_RUN && !ls && STATS && rc < 255) rc++;
            if (q) begin
                nph = P_PULSE;
            end else begin
                case (ph)
                    P_PULSE: if (t == RSTC - 1) nph = P_WAIT;
                    P_WAIT: begin
                        if (ls) nph = P_HOLD;
                        else if (t == TO - 1) begin
                            nph = P_PULSE;
                            if (STATS && tc < 255) tc++;
                        end
                    end
                    P_HOLD: begin
                        if (!ls) nph = P_WAIT;
                        else if (t == HOLD - 1) nph = P_RUN;
                    end
                    default: if (!ls) nph = P_PULSE;
                endcase
            end
            t  = (q || nph != ph) ? 0 : t + 1;
            ph = nph;
            void'(hist.pop_front());
            hist.push_back(l);
        end
        sb.push_back('{(ph == P_PULSE), (ph != P_RUN), (ph == P_RUN), rc, tc});
    endtask

    task automatic step(input bit r, input bit l, input bit q);
        rst = r; locked = l; req_reset = q;
        @(posedge clk);
        model_edge(r, l, q);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    task automatic lock_loss_cycle(input bit with_req);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, with_req);
        repeat (16) step(1'b0, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (pll_rst !== e.pr || sys_rst !== e.sr || ready !== e.rd ||
                relock_count !== 8'(e.rc) || timeout_count_w !== 8'(e.tc)) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: pll_rst/sys_rst/ready/relock/timeout got %b/%b/%b/%0d/%0d, required %b/%b/%b/%0d/%0d",
                         cyc, pll_rst, sys_rst, ready, relock_count, timeout_count_w,
                         e.pr, e.sr, e.rd, e.rc, e.tc);
            end
        end
    end

    initial begin
        rst = 1'b1; locked = 1'b1; req_reset = 1'b0;

        // Power-up with lock present throughout.
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_sys_rst", sys_rst, 1);
        chk("reset_ready", ready, 0);
        chk("reset_relock", relock_count, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("pwr_pll_rst", pll_rst, (i < RSTC) ? 1 : 0);
            chk("pwr_ready", ready, (i >= 13) ? 1 : 0);
            chk("pwr_sys_rst", sys_rst, (i >= 13) ? 0 : 1);
        end

        // Single lock loss in RUN: seen two edges after the first low sample.
        step(1'b0, 1'b0, 1'b0);
        chk("loss_ready_e0", ready, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_ready_e1", ready, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_sys_rst", sys_rst, 1);
        chk("loss_ready", ready, 0);
        chk("loss_relock", relock_count, STATS ? 1 : 0);
        repeat (16) step(1'b0, 1'b1, 1'b0);
        chk("relock_ready", ready, 1);

        // Three more losses, then one coinciding with req_reset.
        repeat (3) lock_loss_cycle(1'b0);
        lock_loss_cycle(1'b1);
        chk("relock_five", relock_count, STATS ? 5 : 0);

        // req_reset from RUN, into HOLD, then rst mid-HOLD.
        step(1'b0, 1'b1, 1'b1);
        chk("req_relock_unchanged", relock_count, STATS ? 5 : 0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        chk("hold_ready", ready, 0);
        chk("hold_pll_rst", pll_rst, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("midhold_rst_pll_rst", pll_rst, 1);
        chk("midhold_rst_sys_rst", sys_rst, 1);
        chk("midhold_rst_ready", ready, 0);
        chk("midhold_rst_relock", relock_count, 0);
        chk("midhold_rst_timeout", timeout_count_w, 0);

        // req_reset while the PLL reset timer is at 2 restarts the pulse.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("req_restart_pll_rst", pll_rst, (k < 4) ? 1 : 0);
        end

        // No lock at all: periodic pulses and timeout counting.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3 * (RSTC + TO); i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("nolock_ready", ready, 0);
        end
        chk("nolock_timeouts", timeout_count_w, STATS ? 3 : 0);

        // One-cycle lock glitch during HOLD forces a fresh full hold.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            step(1'b0, (i == 9) ? 1'b0 : 1'b1, 1'b0);
            if (i >= 10) chk("glitch_ready", ready, (i >= 20) ? 1 : 0);
        end

        // Randomized lock behaviour with sporadic req_reset and rst.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            step(($urandom_range(0, 599) == 0), lk, ($urandom_range(0, 199) == 0));
        end

        // Saturation of the relock counter.
        step(1'b1, 1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b1, 1'b0);
        repeat (300) lock_loss_cycle(1'b0);
        chk("relock_saturated", relock_count, STATS ? 255 : 0);
        chk("final_ready", ready, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
